// File: rtl/stack_register.sv
// LIFO operand stack with push/pop/replace, combinational top/next-of-stack
// taps, fill level and sticky overflow/underflow flags.
module stack_register #(
  parameter int DATA_SIZE = 11,
  parameter int DEPTH     = 16,
  localparam int CNT_SIZE = $clog2(DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  logic                 pop,
  input  logic                 clr_err,
  input  logic [DATA_SIZE-1:0] in,
  output logic [DATA_SIZE-1:0] out,
  output logic [DATA_SIZE-1:0] next,
  output logic [CNT_SIZE-1:0]  count,
  output logic                 empty,
  output logic                 full,
  output logic                 overflow,
  output logic                 underflow
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_SIZE-1:0] mem_q [DEPTH];
  logic [DATA_SIZE-1:0] mem_d [DEPTH];
  logic [CNT_SIZE-1:0]  count_q, count_d;
  logic                 overflow_q, overflow_d;
  logic                 underflow_q, underflow_d;

  logic [CNT_SIZE-1:0]  count_m1, count_m2;
  logic [AW-1:0]        wr_idx, top_idx, nxt_idx;
  logic                 is_empty, is_full;

  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == CNT_SIZE'(DEPTH));
  assign count_m1 = count_q - CNT_SIZE'(1);
  assign count_m2 = count_q - CNT_SIZE'(2);
  assign wr_idx   = count_q[AW-1:0];
  assign top_idx  = count_m1[AW-1:0];
  assign nxt_idx  = count_m2[AW-1:0];

  always_comb begin
    mem_d       = mem_q;
    count_d     = count_q;
    overflow_d  = clr_err ? 1'b0 : overflow_q;
    underflow_d = clr_err ? 1'b0 : underflow_q;

    if (push && pop) begin
      // Replace on a non-empty stack; on an empty one it degrades to a push.
      if (is_empty) begin
        mem_d[wr_idx] = in;
        count_d       = count_q + CNT_SIZE'(1);
      end else begin
        mem_d[top_idx] = in;
      end
    end else if (push) begin
      if (is_full) begin
        overflow_d = 1'b1;
      end else begin
        mem_d[wr_idx] = in;
        count_d       = count_q + CNT_SIZE'(1);
      end
    end else if (pop) begin
      if (is_empty) begin
        underflow_d = 1'b1;
      end else begin
        count_d = count_m1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is deliberately not reset; count gates every read.
  always_ff @(posedge clk) begin
    if (!rst) begin
      mem_q <= mem_d;
    end
  end

  assign out       = (count_q >= CNT_SIZE'(1)) ? mem_q[top_idx] : '0;
  assign next      = (count_q >= CNT_SIZE'(2)) ? mem_q[nxt_idx] : '0;
  assign count     = count_q;
  assign empty     = is_empty;
  assign full      = is_full;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_stack_register.sv
// Table-driven check of stack_register at DEPTH=4, plus hold and reset sequences.
module tb_stack_register;

  localparam int DW = 11;
  localparam int DEPTH = 4;
  localparam int CW = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst, push, pop, clr_err;
  logic [DW-1:0] in, out, next;
  logic [CW-1:0] count;
  logic          empty, full, overflow, underflow;

  int n_pass = 0;
  int n_total = 0;

  stack_register #(.DATA_SIZE(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .clr_err(clr_err), .in(in),
    .out(out), .next(next), .count(count), .empty(empty), .full(full),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          rst, push, pop, clr;
    logic [DW-1:0] din;
    logic [CW-1:0] e_cnt;
    logic [DW-1:0] e_out, e_next;
    logic          e_empty, e_full, e_ovf, e_unf;
  } vec_t;

  vec_t vecs [27];

  function automatic vec_t mk(logic r, logic pu, logic po, logic c, logic [DW-1:0] d,
                              logic [CW-1:0] ec, logic [DW-1:0] eo, logic [DW-1:0] en,
                              logic ee, logic ef, logic eov, logic eun);
    vec_t v;
    v.rst = r; v.push = pu; v.pop = po; v.clr = c; v.din = d;
    v.e_cnt = ec; v.e_out = eo; v.e_next = en;
    v.e_empty = ee; v.e_full = ef; v.e_ovf = eov; v.e_unf = eun;
    return v;
  endfunction

  task automatic step(input logic r, input logic pu, input logic po, input logic c,
                      input logic [DW-1:0] d);
    @(negedge clk);
    rst = r; push = pu; pop = po; clr_err = c; in = d;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [CW-1:0] ec, input logic [DW-1:0] eo,
                       input logic [DW-1:0] en, input logic ee, input logic ef,
                       input logic eov, input logic eun);
    logic [CW+2*DW+3:0] act, exp;
    act = {count, out, next, empty, full, overflow, underflow};
    exp = {ec, eo, en, ee, ef, eov, eun};
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got cnt=%0d out=%h next=%h e=%b f=%b ov=%b un=%b, want cnt=%0d out=%h next=%h e=%b f=%b ov=%b un=%b",
                  name, count, out, next, empty, full, overflow, underflow,
                  ec, eo, en, ee, ef, eov, eun);
  endtask

  initial begin
    rst = 1'b1; push = 1'b0; pop = 1'b0; clr_err = 1'b0; in = '0;

    //               rst push pop clr din      cnt out     next    e  f  ov un
    vecs[0]  = mk(1, 1, 0, 0, 11'h000, 0, 11'h000, 11'h000, 1, 0, 0, 0);
    vecs[1]  = mk(0, 1, 0, 0, 11'h00A, 1, 11'h00A, 11'h000, 0, 0, 0, 0);
    vecs[2]  = mk(0, 1, 0, 0, 11'h00B, 2, 11'h00B, 11'h00A, 0, 0, 0, 0);
    vecs[3]  = mk(0, 1, 0, 0, 11'h00C, 3, 11'h00C, 11'h00B, 0, 0, 0, 0);
    vecs[4]  = mk(0, 1, 0, 0, 11'h00D, 4, 11'h00D, 11'h00C, 0, 1, 0, 0);
    vecs[5]  = mk(0, 1, 0, 0, 11'h7FF, 4, 11'h00D, 11'h00C, 0, 1, 1, 0);
    vecs[6]  = mk(0, 1, 1, 0, 11'h123, 4, 11'h123, 11'h00C, 0, 1, 1, 0);
    vecs[7]  = mk(0, 0, 1, 0, 11'h000, 3, 11'h00C, 11'h00B, 0, 0, 1, 0);
    vecs[8]  = mk(0, 0, 1, 0, 11'h000, 2, 11'h00B, 11'h00A, 0, 0, 1, 0);
    vecs[9]  = mk(0, 0, 1, 0, 11'h000, 1, 11'h00A, 11'h000, 0, 0, 1, 0);
    vecs[10] = mk(0, 0, 1, 0, 11'h000, 0, 11'h000, 11'h000, 1, 0, 1, 0);
    vecs[11] = mk(0, 0, 1, 0, 11'h000, 0, 11'h000, 11'h000, 1, 0, 1, 1);
    vecs[12] = mk(0, 0, 0, 1, 11'h000, 0, 11'h000, 11'h000, 1, 0, 0, 0);
    vecs[13] = mk(0, 0, 1, 1, 11'h000, 0, 11'h000, 11'h000, 1, 0, 0, 1);
    vecs[14] = mk(0, 0, 0, 1, 11'h000, 0, 11'h000, 11'h000, 1, 0, 0, 0);
    vecs[15] = mk(0, 1, 1, 0, 11'h021, 1, 11'h021, 11'h000, 0, 0, 0, 0);
    vecs[16] = mk(0, 1, 0, 0, 11'h022, 2, 11'h022, 11'h021, 0, 0, 0, 0);
    vecs[17] = mk(1, 1, 0, 0, 11'h003, 0, 11'h000, 11'h000, 1, 0, 0, 0);
    vecs[18] = mk(0, 1, 0, 0, 11'h055, 1, 11'h055, 11'h000, 0, 0, 0, 0);
    vecs[19] = mk(0, 0, 1, 0, 11'h000, 0, 11'h000, 11'h000, 1, 0, 0, 0);
    vecs[20] = mk(0, 0, 1, 0, 11'h000, 0, 11'h000, 11'h000, 1, 0, 0, 1);
    vecs[21] = mk(0, 1, 0, 0, 11'h101, 1, 11'h101, 11'h000, 0, 0, 0, 1);
    vecs[22] = mk(0, 1, 0, 0, 11'h202, 2, 11'h202, 11'h101, 0, 0, 0, 1);
    vecs[23] = mk(0, 1, 0, 0, 11'h303, 3, 11'h303, 11'h202, 0, 0, 0, 1);
    vecs[24] = mk(0, 1, 0, 0, 11'h404, 4, 11'h404, 11'h303, 0, 1, 0, 1);
    vecs[25] = mk(0, 1, 0, 1, 11'h505, 4, 11'h404, 11'h303, 0, 1, 1, 0);
    vecs[26] = mk(0, 1, 1, 1, 11'h606, 4, 11'h606, 11'h303, 0, 1, 0, 0);

    for (int i = 0; i < 27; i++) begin
      step(vecs[i].rst, vecs[i].push, vecs[i].pop, vecs[i].clr, vecs[i].din);
      check($sformatf("vec%0d", i), vecs[i].e_cnt, vecs[i].e_out, vecs[i].e_next,
            vecs[i].e_empty, vecs[i].e_full, vecs[i].e_ovf, vecs[i].e_unf);
    end

    // Idle cycles must hold everything, with in toggling underneath.
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0, 11'h7AA);
      check($sformatf("hold%0d", i), 4, 11'h606, 11'h303, 0, 1, 0, 0);
    end

    // Pop down to one entry, then reset together with push+pop discards both.
    step(0, 0, 1, 0, 11'h000);
    check("pop_a", 3, 11'h303, 11'h202, 0, 0, 0, 0);
    step(0, 0, 1, 0, 11'h000);
    step(0, 0, 1, 0, 11'h000);
    check("pop_c", 1, 11'h101, 11'h000, 0, 0, 0, 0);
    step(1, 1, 1, 1, 11'h0FF);
    check("rst_mid", 0, 11'h000, 11'h000, 1, 0, 0, 0);
    step(0, 1, 0, 0, 11'h4C3);
    check("post_rst_push", 1, 11'h4C3, 11'h000, 0, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/stack_register.md
Name: stack_register

Overview:
Parametrised LIFO data stack built from the plain load/increment register idea, with a depth of entries and a push/pop/replace operation set.
- Serves as the operand stack of the stack-architecture datapath.
- Exposes top-of-stack and next-of-stack combinationally, so the ALU can consume two operands per cycle.
- Tracks fill level and flags misuse with sticky overflow/underflow errors.

Parameters:
- DATA_SIZE, 11, width of each stack entry and of in/out/next.
- DEPTH, 16, number of entries; power of two, >= 2.
- CNT_SIZE, $clog2(DEPTH)+1, derived localparam; width of count (holds 0..DEPTH).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- push  input  1  push in onto stack.
- pop  input  1  remove top entry.
- clr_err  input  1  clear sticky error flags.
- in  input  DATA_SIZE  data to push / replace.
- out  output  DATA_SIZE  top-of-stack value.
- next  output  DATA_SIZE  second entry from top.
- count  output  CNT_SIZE  number of valid entries.
- empty  output  1  count == 0.
- full  output  1  count == DEPTH.
- overflow  output  1  sticky: push attempted while full.
- underflow  output  1  sticky: pop attempted while empty.

Behaviour:
- All state updates occur on the rising edge of clk. No asynchronous paths.
- rst has highest priority. At an edge with rst=1, all other inputs are ignored and the following take effect:
  - count=0, empty=1, full=0, overflow=0, underflow=0.
  - out=0, next=0.
  - Storage array contents need not be cleared.
- out = entry[count-1] if count >= 1, else 0. next = entry[count-2] if count >= 2, else 0.
- out and next are pure functions of registered state. The effect of an operation is visible right after the edge that performs it (1-cycle latency, no extra pipeline stage).
- Operations at an edge with rst=0:
  - push=0, pop=0: hold all state.
  - push=1, pop=0, not full: entry[count] <= in; count <= count+1.
  - push=1, pop=0, full: ignored (count and storage unchanged); overflow <= 1.
  - push=0, pop=1, not empty: count <= count-1. Popped data is not erased.
  - push=0, pop=1, empty: ignored; underflow <= 1.
  - push=1, pop=1, not empty: replace top, entry[count-1] <= in; count unchanged; no flag change, even when full.
  - push=1, pop=1, empty: behaves as a plain push (count becomes 1); underflow is not set.
- empty and full are decoded from count every cycle and are never stale.
- Sticky flags:
  - clr_err=1 clears overflow and underflow at the edge.
  - If a new error occurs at the same edge, that flag is set (set wins over clear); the other flag still clears.
- count arithmetic is unsigned. count never wraps past DEPTH or below 0; the guarded cases above make wrap impossible.
- Reset mid-operation, e.g. rst=1 together with push=1: the reset result applies and push is discarded.

Test Plan (DATA_SIZE=11, DEPTH=4):
1. Hold rst=1 for one edge, then release -> count=0, empty=1, full=0, out=0, next=0, overflow=0, underflow=0.
2. Push 0x00A, 0x00B, 0x00C on consecutive edges -> out = 10, 11, 12 after each edge respectively; after the third edge next=11, count=3, empty=0.
3. Push 0x00D -> count=4, full=1, out=13. Then push 0x7FF -> count stays 4, out=13, overflow=1.
4. Assert push=1 and pop=1 with in=0x123 at full -> out=0x123, next=12, count=4, no new flag set.
5. Pop four times -> out = 12, 11, 10, 0 and next = 11, 10, 0, 0 after each pop; empty=1. Pop again -> underflow=1, count=0. Then assert clr_err -> overflow=0, underflow=0. Also assert clr_err together with an empty pop -> underflow stays 1.
6. Reach count=2, then drive rst=1 with push=1 at the same edge -> count=0, empty=1, out=0, all flags 0. Then push 0x055 -> out=0x055, count=1.
